clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures the period and high time of a slow, asynchronous square wave (e.g. the 1 Hz game tick or any divided clock) in units of the `clk_in` system clock. Results are handed to downstream logic (display, self-test, score timer) over a valid/ready handshake. It is the receive-side check for our clock dividers: a divider turns a cycle count into a waveform; this block turns the waveform back into a cycle count.

## Interface
- `CNT_W`, 26: width of the period/high-time counters and result outputs.
- `TIMEOUT`, 50_000_000: cycles without a rising edge before a timeout is declared; must satisfy 2 ≤ TIMEOUT < 2^CNT_W.

Ports:
- `clk_in`  in  1  system clock (50 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `sig_in`  in  1  asynchronous slow signal to measure.
- `period`  out  CNT_W  cycles between the last two rising edges.
- `high_time`  out  CNT_W  cycles `sig` was high within that period.
- `meas_valid`  out  1  result available.
- `meas_ready`  in  1  consumer accepts the result.
- `timeout`  out  1  sticky: no rising edge for TIMEOUT cycles.
- `overrun`  out  1  sticky: an unaccepted result was overwritten.
- `busy`  out  1  high while in MEASURE.

## Operation
- Front end: `sig_in` passes through a 2-flop synchronizer, then the optional filter (see Configuration), giving level `sig`. A 1-cycle `rise` pulse is generated when `sig` goes 0→1.
- FSM states: ARMED, MEASURE. Reset state: ARMED.
- ARMED: on `rise` → MEASURE, `cnt`←1, `hi_cnt`←1. There is no result for the first edge.
- MEASURE, no `rise`: `cnt`←`cnt`+1; `hi_cnt`←`hi_cnt`+`sig`. If `cnt` = TIMEOUT−1 in this cycle: `timeout`←1, → ARMED, no result is produced.
- MEASURE, `rise`: `period`←`cnt`, `high_time`←`hi_cnt`, `meas_valid`←1, `cnt`←1, `hi_cnt`←1, `timeout`←0; stay in MEASURE.
- Counters never wrap: the timeout fires before `cnt` can reach 2^CNT_W.
- Handshake: the result registers hold steady while `meas_valid`=1 and no new result is produced. On `meas_valid`&`meas_ready`, `meas_valid`←0 next cycle.
- Simultaneous accept and new result: the new result is loaded, `meas_valid` stays 1, and `overrun` is unchanged.
- New result while `meas_valid`=1 and `meas_ready`=0: the data is overwritten, `meas_valid` stays 1, and `overrun`←1.
- `overrun` clears only on `rst`. `timeout` clears on `rst` or on the next produced result.
- `busy` = (state == MEASURE).
- Reset mid-measurement: all state is discarded and the block returns to ARMED. The synchronizer/filter flops reset to 0, so a `sig_in` that is high at reset release does not generate `rise` until it goes low then high again.

## Timing
- Reset values: `period`=0, `high_time`=0, `meas_valid`=0, `timeout`=0, `overrun`=0, `busy`=0.
- `sig_in` edge to `rise`: 3 cycles without the filter, 6 cycles with it. Both edges see the same delay, so `period` and `high_time` are exact.
- `rise` to `meas_valid`/data update: 1 cycle (registered outputs).
- Minimum measurable period: 2 cycles.
- All outputs are registered; `meas_ready` is not combinationally connected to any output.

## Configuration
- `CLK_PERIOD_METER_FILTER_EN` defined: a glitch filter follows the synchronizer. `sig` changes only after 4 consecutive identical synchronized samples, which adds 3 cycles of latency. Pulses shorter than 4 cycles are ignored.
- Not defined: `sig` is the synchronizer output directly, and every edge is measured.

## Test plan
- Reset, then `sig_in` with period 10 and high 5, `meas_ready`=1: first result `period`=10, `high_time`=5; `meas_valid` pulses 1 cycle per period. Nothing is reported for the first edge.
- Period 50_000_002, high 25_000_001 (divider output): `period`=50_000_002, `high_time`=25_000_001, `timeout`=0, with TIMEOUT overridden to 60_000_000.
- `sig_in` held low after one rising edge, TIMEOUT=100: `timeout`=1 exactly 100 cycles after `rise`, `busy`=0. The next two edges produce a result and clear `timeout`.
- `meas_ready`=0 across two periods of 8: `meas_valid` stays 1, data = second result, `overrun`=1. Then `meas_ready`=1 accepts and `meas_valid` drops next cycle.
- Accept in the same cycle a new result arrives: `meas_valid` stays 1, data updates, `overrun` stays 0.
- Filter on: a 2-cycle high glitch inside a low phase does not change `period`. Filter off: the same glitch produces a short-period result. `rst` asserted mid-period returns all outputs to reset values next cycle.

Source files
------------

// File: rtl/clk_period_meter.sv
// clk_period_meter: period and high time of a slow async signal, counted in clk_in cycles.
// Define CLK_PERIOD_METER_FILTER_EN to insert a 4-sample glitch filter after the synchronizer.
module clk_period_meter #(
    parameter int CNT_W   = 26,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             timeout,
    output logic             overrun,
    output logic             busy
);
    typedef enum logic {ARMED, MEASURE} state_t;
    state_t state_q, state_d;
    logic s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d, rise_q, rise_d, sig;
    logic primed_q, primed_d, low_seen_q, low_seen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hi_q, hi_d, period_q, period_d, high_q, high_d;
    logic valid_q, valid_d, tmo_q, tmo_d, ovr_q, ovr_d;
`ifdef CLK_PERIOD_METER_FILTER_EN
    logic [1:0] sh_q, sh_d;
    logic filt_q, filt_d;
    assign sig = filt_q;
`else
    assign sig = s2_q;
`endif
    always_comb begin
        s1_d = sig_in;
        s2_d = s1_q;
`ifdef CLK_PERIOD_METER_FILTER_EN
        sh_d = {sh_q[0], s2_q};
        filt_d = (s1_q == s2_q && sh_q == {2{s2_q}}) ? s2_q : filt_q;
`endif
        // A rise only counts once a real low has been sampled after reset
        primed_d = 1'b1;
        low_seen_d = low_seen_q | (primed_q & ~s1_q);
        lvl_d = sig;
        rise_d = sig & ~lvl_q & low_seen_q;
        state_d = state_q;
        cnt_d = (state_q == MEASURE) ? cnt_q + CNT_W'(1) : cnt_q;
        hi_d = (state_q == MEASURE) ? hi_q + CNT_W'(lvl_q) : hi_q;
        period_d = period_q;
        high_d = high_q;
        valid_d = valid_q & ~meas_ready;
        tmo_d = tmo_q;
        ovr_d = ovr_q;
        if (rise_q) begin
            state_d = MEASURE;
            cnt_d = CNT_W'(1);
            hi_d = CNT_W'(1);
            if (state_q == MEASURE) begin
                period_d = cnt_q;
                high_d = hi_q;
                valid_d = 1'b1;
                ovr_d = ovr_q | (valid_q & ~meas_ready);
                tmo_d = 1'b0;
            end
        end else if (state_q == MEASURE && cnt_q == CNT_W'(TIMEOUT - 1)) begin
            tmo_d = 1'b1;
            state_d = ARMED;
        end
    end
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= ARMED;
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            lvl_q <= 1'b0;
            rise_q <= 1'b0;
            primed_q <= 1'b0;
            low_seen_q <= 1'b0;
            cnt_q <= '0;
            hi_q <= '0;
            period_q <= '0;
            high_q <= '0;
            valid_q <= 1'b0;
            tmo_q <= 1'b0;
            ovr_q <= 1'b0;
`ifdef CLK_PERIOD_METER_FILTER_EN
            sh_q <= '0;
            filt_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            lvl_q <= lvl_d;
            rise_q <= rise_d;
            primed_q <= primed_d;
            low_seen_q <= low_seen_d;
            cnt_q <= cnt_d;
            hi_q <= hi_d;
            period_q <= period_d;
            high_q <= high_d;
            valid_q <= valid_d;
            tmo_q <= tmo_d;
            ovr_q <= ovr_d;
`ifdef CLK_PERIOD_METER_FILTER_EN
            sh_q <= sh_d;
            filt_q <= filt_d;
`endif
        end
    end
    assign period = period_q;
    assign high_time = high_q;
    assign meas_valid = valid_q;
    assign timeout = tmo_q;
    assign overrun = ovr_q;
    assign busy = (state_q == MEASURE);
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed waveforms checked every cycle against a cycle-stamp model plus literal expectations.
module tb_clk_period_meter;
    localparam int CW = 8;
    localparam int TO = 100;
    logic clk_in = 1'b0;
    logic rst = 1'b1;
    logic sig_in = 1'b0;
    logic meas_ready = 1'b0;
    logic [CW-1:0] period, high_time;
    logic meas_valid, timeout, overrun, busy;
    int n_vec = 0, n_err = 0, cyc = 0, mv_cycles = 0;
    bit rdy_v = 1'b0, sync_acc = 1'b0;
    bit smp[5];
    bit rv[5];
    bit m_f, m_l, m_r, m_seen, m_busy, m_mv, m_to, m_ov;
    int m_per, m_hi, t_rise, hi_acc;

    clk_period_meter #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .period(period), .high_time(high_time),
        .meas_valid(meas_valid), .meas_ready(meas_ready), .timeout(timeout), .overrun(overrun), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Model: sig is sig_in delayed 3 cycles (or filtered); results are differences of rise cycle stamps.
    task automatic model_edge();
        bit nr, l_new;
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                smp[i] = 1'b0;
                rv[i] = 1'b0;
            end
            {m_f, m_l, m_r, m_seen, m_busy, m_mv, m_to, m_ov} = '0;
            m_per = 0;
            m_hi = 0;
        end else begin
            nr = 1'b0;
            if (m_busy) begin
                if (m_r) begin
                    nr = 1'b1;
                    if (m_mv && !meas_ready) m_ov = 1'b1;
                    m_per = cyc - t_rise;
                    m_hi = hi_acc;
                    m_to = 1'b0;
                    t_rise = cyc;
                    hi_acc = 1;
                end else if (cyc - t_rise == TO - 1) begin
                    m_to = 1'b1;
                    m_busy = 1'b0;
                end else begin
                    hi_acc += int'(m_l);
                end
            end else if (m_r) begin
                m_busy = 1'b1;
                t_rise = cyc;
                hi_acc = 1;
            end
            if (nr) m_mv = 1'b1;
            else if (meas_ready) m_mv = 1'b0;
            for (int i = 4; i > 0; i--) begin
                smp[i] = smp[i-1];
                rv[i] = rv[i-1];
            end
            smp[0] = sig_in;
            rv[0] = 1'b1;
            if (rv[2] && !smp[2]) m_seen = 1'b1;
`ifdef CLK_PERIOD_METER_FILTER_EN
            l_new = m_f;
            if (smp[1] == smp[2] && smp[2] == smp[3] && smp[3] == smp[4]) m_f = smp[1];
`else
            l_new = smp[2];
`endif
            m_r = l_new && !m_l && m_seen;
            m_l = l_new;
        end
        cyc++;
    endtask

    task automatic step(input bit s);
        @(negedge clk_in);
        sig_in = s;
        meas_ready = sync_acc ? m_r : rdy_v;
        @(posedge clk_in);
        model_edge();
        #1;
        n_vec++;
        if ({period, high_time, meas_valid, timeout, overrun, busy} !==
            {CW'(m_per), CW'(m_hi), m_mv, m_to, m_ov, m_busy}) begin
            n_err++;
            $display("FAIL cycle %0d: got per=%0d hi=%0d v=%b to=%b ov=%b busy=%b, want per=%0d hi=%0d v=%b to=%b ov=%b busy=%b",
                     cyc, period, high_time, meas_valid, timeout, overrun, busy,
                     m_per, m_hi, m_mv, m_to, m_ov, m_busy);
        end
        if (meas_valid) mv_cycles++;
    endtask

    task automatic seg(input bit l, input int n);
        repeat (n) step(l);
    endtask

    task automatic wave(input int p, input int h, input int n);
        repeat (n) begin
            seg(1'b1, h);
            seg(1'b0, p - h);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seg(1'b0, 2);
        rst = 1'b0;
        seg(1'b0, 4);
    endtask

    initial begin
        rst = 1'b1;
        seg(1'b0, 2);
        chk("rst period", int'(period), 0);
        chk("rst high_time", int'(high_time), 0);
        chk("rst meas_valid", int'(meas_valid), 0);
        chk("rst timeout", int'(timeout), 0);
        chk("rst overrun", int'(overrun), 0);
        chk("rst busy", int'(busy), 0);
        rst = 1'b0;
        seg(1'b0, 4);
        rdy_v = 1'b1;
        mv_cycles = 0;
        wave(10, 5, 4);
        chk("p10 period", int'(period), 10);
        chk("p10 high_time", int'(high_time), 5);
        chk("p10 valid pulses", mv_cycles, 3);

        do_reset();
        rdy_v = 1'b1;
        wave(10, 5, 2);
        seg(1'b0, 110);
        chk("tmo timeout", int'(timeout), 1);
        chk("tmo busy", int'(busy), 0);
        wave(10, 5, 2);
        chk("tmo clear", int'(timeout), 0);
        chk("tmo next period", int'(period), 10);
        wave(99, 50, 2);
        chk("max period", int'(period), 99);
        chk("max high_time", int'(high_time), 50);
        chk("max no timeout", int'(timeout), 0);
        wave(100, 50, 2);
        chk("p100 timeout", int'(timeout), 1);
        chk("p100 rearmed busy", int'(busy), 1);

        do_reset();
        rdy_v = 1'b0;
        wave(9, 4, 1);
        wave(8, 4, 1);
        wave(8, 4, 1);
        chk("ovr valid", int'(meas_valid), 1);
        chk("ovr overrun", int'(overrun), 1);
        chk("ovr period second", int'(period), 8);
        rdy_v = 1'b1;
        step(1'b0);
        rdy_v = 1'b0;
        chk("ovr accept drops valid", int'(meas_valid), 0);
        chk("ovr sticky", int'(overrun), 1);

        do_reset();
        rdy_v = 1'b0;
        wave(9, 4, 1);
        wave(8, 4, 1);
        sync_acc = 1'b1;
        wave(8, 4, 1);
        seg(1'b0, 4);
        sync_acc = 1'b0;
        chk("sync valid", int'(meas_valid), 1);
        chk("sync overrun", int'(overrun), 0);
        chk("sync period", int'(period), 8);

        do_reset();
        rdy_v = 1'b1;
        repeat (3) begin
            seg(1'b1, 6);
            seg(1'b0, 4);
            seg(1'b1, 2);
            seg(1'b0, 4);
        end
        seg(1'b1, 6);
        seg(1'b0, 10);
`ifdef CLK_PERIOD_METER_FILTER_EN
        chk("glitch period", int'(period), 16);
        chk("glitch high_time", int'(high_time), 6);
`else
        chk("glitch period", int'(period), 6);
        chk("glitch high_time", int'(high_time), 2);
`endif

        do_reset();
        rdy_v = 1'b1;
        wave(10, 5, 2);
        seg(1'b1, 3);
        chk("mid busy", int'(busy), 1);
        rst = 1'b1;
        step(1'b1);
        chk("mid rst period", int'(period), 0);
        chk("mid rst high_time", int'(high_time), 0);
        chk("mid rst valid", int'(meas_valid), 0);
        chk("mid rst busy", int'(busy), 0);
        rst = 1'b0;
        seg(1'b1, 10);
        chk("high at release no rise", int'(busy), 0);
        seg(1'b0, 5);
        seg(1'b1, 8);
        chk("rise after low", int'(busy), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
